pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the 5-stage (IF/ID/EX/MEM/WB) RISC-V pipeline.
- Replaces ad-hoc load-use handling with a proper one-bubble stall, and squashes wrong-path instructions on taken branches/jumps resolved in EX.
- Sequences a multi-cycle mul/div unit (MDU) and a wait-stated data bus through a small FSM.
- Drives the hold/flush inputs of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, and keeps performance counters.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/perf_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline hazard controller
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  // Winning hazard cause for the current cycle, highest priority first after NONE
  typedef enum logic [2:0] {NONE, MEMW, MDU, REDIR, LU} cause_t;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter with synchronous clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_wait,
  input  logic             cnt_clr,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             mdu_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_VAL = TW'(MDU_TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_d;
  logic          lu, timeout, mdu_stall;
  cause_t        cause;

  assign lu = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // A timed-out op is released exactly like a completed one
  assign timeout   = (state_q == MDU_BUSY) & ~mdu_done & (tcnt_q == TO_VAL);
  assign mdu_stall = ~timeout &
                     (((state_q == MDU_BUSY) & ~mdu_done) |
                      ((state_q == RUN) & ex_valid & ex_mdu_start & ~mdu_done));

  always_comb begin
    cause = NONE;
    if (!rst_n)          cause = NONE;
    else if (mem_wait)   cause = MEMW;
    else if (mdu_stall)  cause = MDU;
    else if (ex_redirect) cause = REDIR;
    else if (lu)         cause = LU;
  end

  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    case (cause)
      MEMW: begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_hold   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      MDU: begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
      end
      REDIR: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      LU: begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // A stalled data bus freezes the whole sequencer, timeout counter included
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    err_d   = mdu_timeout_err;
    if (!mem_wait) begin
      case (state_q)
        RUN: begin
          if (ex_valid & ex_mdu_start & ~mdu_done) begin
            state_d = MDU_BUSY;
            tcnt_d  = TW'(1);
          end
        end
        MDU_BUSY: begin
          if (mdu_done) begin
            state_d = RUN;
            tcnt_d  = '0;
          end else if (timeout) begin
            state_d = RUN;
            tcnt_d  = '0;
            err_d   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      tcnt_q          <= '0;
      mdu_timeout_err <= 1'b0;
    end else begin
      state_q         <= state_d;
      tcnt_q          <= tcnt_d;
      mdu_timeout_err <= err_d;
    end
  end

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (pc_hold),
    .count (stall_cycles)
  );

  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cause == REDIR),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_valid, ex_is_load, ex_redirect, ex_mdu_start, mdu_done, mem_wait, cnt_clr;
  logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic ex_mem_hold, ex_mem_bubble, mem_wb_bubble, mdu_timeout_err;
  logic [CW-1:0] stall_cycles, flush_count;

  logic [7:0]  ctrl;
  logic [24:0] obs;
  assign ctrl = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                 ex_mem_hold, ex_mem_bubble, mem_wb_bubble};
  assign obs  = {ctrl, stall_cycles, flush_count, mdu_timeout_err};

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_busy;
  int m_cnt;
  bit m_err;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_wait(mem_wait), .cnt_clr(cnt_clr),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_bubble(mem_wb_bubble), .mdu_timeout_err(mdu_timeout_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // 0 none, 1 bus wait, 2 mdu, 3 redirect, 4 load-use
  function automatic int exp_cause();
    bit lu, to, ms;
    if (!rst_n) return 0;
    lu = ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    to = m_busy && !mdu_done && m_cnt >= TO;
    ms = !to && (m_busy ? !mdu_done : (ex_valid && ex_mdu_start && !mdu_done));
    if (mem_wait) return 1;
    if (ms) return 2;
    if (ex_redirect) return 3;
    if (lu) return 4;
    return 0;
  endfunction

  function automatic logic [24:0] exp_all();
    logic [7:0] c;
    logic [CW-1:0] s, f;
    case (exp_cause())
      1: c = 8'b11010101;
      2: c = 8'b11010010;
      3: c = 8'b00101000;
      4: c = 8'b11001000;
      default: c = 8'b0;
    endcase
    s = CW'(m_stall);
    f = CW'(m_flush);
    return {c, s, f, m_err};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic tick();
    int cz;
    cz = exp_cause();
    if (cnt_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (cz == 1 || cz == 2 || cz == 4) m_stall = (m_stall + 1) % (1 << CW);
      if (cz == 3) m_flush = (m_flush + 1) % (1 << CW);
    end
    if (rst_n && !mem_wait) begin
      if (m_busy) begin
        if (mdu_done) m_busy = 0;
        else if (m_cnt >= TO) begin m_busy = 0; m_err = 1; end
        else m_cnt++;
      end else if (ex_valid && ex_mdu_start && !mdu_done) begin
        m_busy = 1; m_cnt = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_redirect = 0;
    ex_mdu_start = 0; mdu_done = 0; mem_wait = 0; cnt_clr = 0;
  endtask

  task automatic clear_counters();
    idle(); cnt_clr = 1; tick(); cnt_clr = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs !== 25'b0) begin bad++; $display("FAIL reset_state: got %h want 0", obs); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    clear_counters();
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b11001000) begin bad++; $display("FAIL lu_stall: got %b want 11001000", ctrl); end
    tick();
    ex_valid = 0; ex_is_load = 0;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b0 || stall_cycles !== 8'd1) begin
      bad++; $display("FAIL lu_after: ctrl %b stall %0d want 0 and 1", ctrl, stall_cycles);
    end
    tick();
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b0) begin bad++; $display("FAIL lu_rd0: got %b want 0", ctrl); end
    tick(); idle();
  endtask

  task automatic test_redirect_lu();
    clear_counters();
    ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_valid = 1; id_use_rs2 = 1; id_rs2 = 7;
    ex_redirect = 1;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b00101000) begin bad++; $display("FAIL redir_lu: got %b want 00101000", ctrl); end
    tick(); idle();
    @(negedge clk);
    total++;
    if (flush_count !== 8'd1 || stall_cycles !== 8'd0) begin
      bad++; $display("FAIL redir_cnt: flush %0d stall %0d want 1 and 0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_mdu();
    clear_counters();
    ex_valid = 1; ex_mdu_start = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== 8'b11010010) begin bad++; $display("FAIL mdu_hold%0d: got %b want 11010010", i, ctrl); end
      tick();
    end
    mdu_done = 1;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b0) begin bad++; $display("FAIL mdu_release: got %b want 0", ctrl); end
    tick(); idle();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'd5 || ctrl !== 8'b0) begin
      bad++; $display("FAIL mdu_count: stall %0d ctrl %b want 5 and 0", stall_cycles, ctrl);
    end
    ex_valid = 1; ex_mdu_start = 1; mdu_done = 1;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b0) begin bad++; $display("FAIL mdu_single: got %b want 0", ctrl); end
    tick(); idle();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'd5) begin bad++; $display("FAIL mdu_single_cnt: got %0d want 5", stall_cycles); end
  endtask

  task automatic test_timeout();
    clear_counters();
    ex_valid = 1; ex_mdu_start = 1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== 8'b11010010) begin bad++; $display("FAIL to_hold%0d: got %b want 11010010", i, ctrl); end
      tick();
    end
    @(negedge clk);
    total++;
    if (ctrl !== 8'b0 || mdu_timeout_err !== 1'b0) begin
      bad++; $display("FAIL to_release: ctrl %b err %b want 0 and 0", ctrl, mdu_timeout_err);
    end
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (mdu_timeout_err !== 1'b1 || stall_cycles !== 8'd8) begin
        bad++; $display("FAIL to_sticky%0d: err %b stall %0d want 1 and 8", i, mdu_timeout_err, stall_cycles);
      end
      tick();
    end
  endtask

  task automatic test_memwait_redirect();
    clear_counters();
    ex_valid = 1; ex_redirect = 1; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ctrl !== 8'b11010101) begin bad++; $display("FAIL memw_hold%0d: got %b want 11010101", i, ctrl); end
      tick();
    end
    mem_wait = 0;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b00101000) begin bad++; $display("FAIL memw_flush: got %b want 00101000", ctrl); end
    tick(); idle();
    @(negedge clk);
    total++;
    if (flush_count !== 8'd1 || stall_cycles !== 8'd3) begin
      bad++; $display("FAIL memw_cnt: flush %0d stall %0d want 1 and 3", flush_count, stall_cycles);
    end
  endtask

  task automatic test_cnt_clr_wrap();
    clear_counters();
    mem_wait = 1;
    repeat (260) tick();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'd4) begin bad++; $display("FAIL wrap: got %0d want 4", stall_cycles); end
    cnt_clr = 1;
    tick();
    idle();
    @(negedge clk);
    total++;
    if (stall_cycles !== 8'd0) begin bad++; $display("FAIL clr_vs_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_async_reset();
    idle();
    ex_valid = 1; ex_mdu_start = 1;
    tick(); tick();
    #1 rst_n = 0;
    model_reset();
    #1;
    total++;
    if (obs !== 25'b0) begin bad++; $display("FAIL async_reset: got %h want 0", obs); end
    ex_valid = 0; ex_mdu_start = 0; mdu_done = 1;
    @(negedge clk);
    rst_n = 1;
    #1;
    total++;
    if (ctrl !== 8'b0) begin bad++; $display("FAIL late_done: got %b want 0", ctrl); end
    tick();
    ex_valid = 1; ex_mdu_start = 1; mdu_done = 0;
    @(negedge clk);
    total++;
    if (ctrl !== 8'b11010010) begin bad++; $display("FAIL run_after_reset: got %b want 11010010", ctrl); end
    tick();
    mdu_done = 1;
    tick(); idle();
  endtask

  task automatic test_random();
    logic [24:0] e;
    for (int i = 0; i < 800; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = $urandom_range(0, 1) == 1;
      id_use_rs2   = $urandom_range(0, 1) == 1;
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_is_load   = $urandom_range(0, 1) == 1;
      ex_redirect  = ($urandom_range(0, 4) == 0);
      ex_mdu_start = ($urandom_range(0, 5) == 0);
      mdu_done     = ($urandom_range(0, 5) == 0);
      mem_wait     = ($urandom_range(0, 4) == 0);
      cnt_clr      = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      e = exp_all();
      total++;
      if (obs !== e) begin bad++; $display("FAIL random%0d: got %h want %h", i, obs, e); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_lu();
    test_mdu();
    test_timeout();
    test_memwait_redirect();
    test_cnt_clr_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
